// File: rtl/axis_pixels_arbiter.sv
// axis_pixels_arbiter
//   Packet-level round-robin arbiter: N_SRC pixel streams share one output.
//   A grant covers a whole image (header beat + pixel beats up to s_last).
//   It is only released after the image's last beat is accepted, so header
//   and pixel beats from different sources never interleave. Every output
//   beat carries the granted source index (m_src). m_first marks the header
//   beat.
//
//   Optional macro AXIS_PIXELS_ARB_REG_OUT_EN:
//     defined   - output through a 2-entry skid buffer. All m_* are
//                 registered, with 1 cycle latency. Granted ready = !full.
//     undefined - combinational output mux with 0 cycle latency. Granted
//                 ready = m_ready.
//
// Ports
//   aclk, rst        clock, synchronous active-high reset
//   s_valid/s_ready  per-source handshake
//   s_last/s_data/s_keep  per-source payload
//   m_valid/m_ready  output handshake
//   m_last/m_data/m_keep  output payload
//   m_src            granted source index for this beat
//   m_first          header (config) beat of an image
//   busy             a grant is held (state is not S_IDLE)
module axis_pixels_arbiter #(
    parameter int N_SRC      = 2,
    parameter int WORD_WIDTH = 8,
    parameter int WORDS      = 8,
    parameter int BITS_SRC   = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
    input  logic                                        aclk,
    input  logic                                        rst,
    input  logic [N_SRC-1:0]                            s_valid,
    output logic [N_SRC-1:0]                            s_ready,
    input  logic [N_SRC-1:0]                            s_last,
    input  logic [N_SRC-1:0][WORDS-1:0][WORD_WIDTH-1:0] s_data,
    input  logic [N_SRC-1:0][WORDS-1:0]                 s_keep,
    output logic                                        m_valid,
    input  logic                                        m_ready,
    output logic                                        m_last,
    output logic [WORDS-1:0][WORD_WIDTH-1:0]            m_data,
    output logic [WORDS-1:0]                            m_keep,
    output logic [BITS_SRC-1:0]                         m_src,
    output logic                                        m_first,
    output logic                                        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_BODY = 2'd2
    } state_t;

    state_t                           state;
    logic [BITS_SRC-1:0]              grant;
    logic [BITS_SRC-1:0]              last_grant;
    logic [BITS_SRC-1:0]              next_grant;
    logic [BITS_SRC-1:0]              cand;
    logic                             found;
    logic                             src_ready;  // ready offered to the granted source
    logic                             acc;        // granted source beat accepted this cycle

    logic                             g_valid;
    logic                             g_last;
    logic [WORDS-1:0][WORD_WIDTH-1:0] g_data;
    logic [WORDS-1:0]                 g_keep;

    assign g_valid = s_valid[grant];
    assign g_last  = s_last[grant];
    assign g_data  = s_data[grant];
    assign g_keep  = s_keep[grant];
    assign acc     = busy && g_valid && src_ready;

    // Round-robin search: walk upward from last_grant+1 with wrap at N_SRC-1.
    // The walk covers every source, ending at last_grant itself.
    always_comb begin
        next_grant = last_grant;
        found      = 1'b0;
        cand       = last_grant;
        for (int i = 0; i < N_SRC; i++) begin
            cand = (cand == BITS_SRC'(N_SRC - 1)) ? '0 : cand + BITS_SRC'(1);
            if (!found && s_valid[cand]) begin
                next_grant = cand;
                found      = 1'b1;
            end
        end
    end

    // Grant FSM. busy is kept as its own flop so it is a clean registered
    // output that mirrors state != S_IDLE.
    always_ff @(posedge aclk) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_grant <= BITS_SRC'(N_SRC - 1);
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|s_valid) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        state      <= S_HDR;
                        busy       <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (acc) begin
                        state <= g_last ? S_IDLE : S_BODY;
                        busy  <= !g_last;
                    end
                end
                S_BODY: begin
                    if (acc && g_last) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Only the granted source ever sees ready.
    for (genvar i = 0; i < N_SRC; i++) begin : g_ready
        assign s_ready[i] = busy && (grant == BITS_SRC'(i)) && src_ready;
    end

`ifdef AXIS_PIXELS_ARB_REG_OUT_EN

    typedef struct packed {
        logic                             last;
        logic                             first;
        logic [BITS_SRC-1:0]              src;
        logic [WORDS-1:0]                 keep;
        logic [WORDS-1:0][WORD_WIDTH-1:0] data;
    } beat_t;

    beat_t in_beat;
    beat_t e0;     // head entry, drives m_*
    beat_t e1;     // skid entry
    logic  v0;
    logic  v1;
    logic  pop;

    assign in_beat = '{last: g_last, first: (state == S_HDR), src: grant,
                       keep: g_keep, data: g_data};
    assign pop       = v0 && m_ready;
    // Accept only while the skid slot is free. A pop frees a slot, but using
    // it here would put m_ready on the s_ready path.
    assign src_ready = !v1;

    always_ff @(posedge aclk) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            e0 <= '0;
            e1 <= '0;
        end else begin
            if (pop) begin
                e0 <= e1;
                v0 <= v1;
                v1 <= 1'b0;
            end
            // acc implies !v1, so the head slot is free after a pop or when empty.
            if (acc) begin
                if (pop || !v0) begin
                    e0 <= in_beat;
                    v0 <= 1'b1;
                end else begin
                    e1 <= in_beat;
                    v1 <= 1'b1;
                end
            end
        end
    end

    assign m_valid = v0;
    assign m_last  = e0.last;
    assign m_first = e0.first;
    assign m_src   = e0.src;
    assign m_keep  = e0.keep;
    assign m_data  = e0.data;

`else

    assign src_ready = m_ready;
    assign m_valid   = busy && g_valid;
    assign m_last    = busy && g_last;
    assign m_first   = (state == S_HDR);
    assign m_src     = busy ? grant  : '0;
    assign m_keep    = busy ? g_keep : '0;
    assign m_data    = busy ? g_data : '0;

`endif

endmodule

// File: tb/tb_axis_pixels_arbiter.sv
// Self-checking bench for axis_pixels_arbiter (N_SRC=3).
// Sources are queues of whole images. The reference model picks grants by
// round-robin over the sources requesting while the arbiter is idle. It keeps
// an ordered list of accepted beats, which the output must reproduce exactly.
module tb_axis_pixels_arbiter;
    localparam int N_SRC      = 3;
    localparam int WORD_WIDTH = 8;
    localparam int WORDS      = 4;
    localparam int BITS_SRC   = 2;
    localparam int DW         = WORDS * WORD_WIDTH;

    logic                                        aclk = 1'b0;
    logic                                        rst  = 1'b1;
    logic [N_SRC-1:0]                            s_valid = '0;
    logic [N_SRC-1:0]                            s_ready;
    logic [N_SRC-1:0]                            s_last = '0;
    logic [N_SRC-1:0][WORDS-1:0][WORD_WIDTH-1:0] s_data = '0;
    logic [N_SRC-1:0][WORDS-1:0]                 s_keep = '0;
    logic                                        m_valid;
    logic                                        m_ready = 1'b1;
    logic                                        m_last;
    logic [WORDS-1:0][WORD_WIDTH-1:0]            m_data;
    logic [WORDS-1:0]                            m_keep;
    logic [BITS_SRC-1:0]                         m_src;
    logic                                        m_first;
    logic                                        busy;

    always #5 aclk = ~aclk;

    axis_pixels_arbiter #(
        .N_SRC(N_SRC), .WORD_WIDTH(WORD_WIDTH), .WORDS(WORDS), .BITS_SRC(BITS_SRC)
    ) dut (
        .aclk(aclk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .s_data(s_data), .s_keep(s_keep),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .m_data(m_data), .m_keep(m_keep), .m_src(m_src),
        .m_first(m_first), .busy(busy)
    );

    typedef struct {
        logic [DW-1:0]    data;
        logic [WORDS-1:0] keep;
        logic             last;
    } in_beat_t;

    typedef struct {
        logic [DW-1:0]    data;
        logic [WORDS-1:0] keep;
        logic             last;
        logic             first;
        int               src;
    } out_beat_t;

    in_beat_t  src_q[N_SRC][$];
    out_beat_t exp_q[$];
    int        hdr_log[$];
    int        gap_log[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit               mdl_busy = 1'b0;
    int               mdl_grant = 0;
    int               mdl_last = N_SRC - 1;
    int               mdl_idx = 0;
    logic [N_SRC-1:0] acc = '0;
    int               rdy_mode = 0;
    int               rdy_cnt = 0;
    int               gap_pct = 0;
    int               out_cnt = 0;
    int               req_cyc = -1;
    int               out_cyc = -1;
    bit               stall_prev = 1'b0;
    logic [63:0]      stall_val = '0;
    int               idle_run = 0;
    bit               seen_busy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic bit_at(input logic [N_SRC-1:0] v, input int i);
        logic [N_SRC-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // First requester strictly after 'last', wrapping modulo N_SRC.
    function automatic int rr_pick(input logic [N_SRC-1:0] v, input int last);
        for (int k = 1; k <= N_SRC; k++) begin
            if (bit_at(v, (last + k) % N_SRC)) return (last + k) % N_SRC;
        end
        return last;
    endfunction

    function automatic logic [63:0] pack(input logic l, input logic f, input int s,
                                         input logic [WORDS-1:0] k, input logic [DW-1:0] d);
        logic [BITS_SRC-1:0] sb;
        sb = BITS_SRC'(s);
        return 64'({l, f, sb, k, d});
    endfunction

    // Header order as decimal digits (src+1), e.g. 0,1,0,1 -> 1212.
    function automatic int enc_log();
        int v = 0;
        foreach (hdr_log[i]) v = v * 10 + hdr_log[i] + 1;
        return v;
    endfunction

    task automatic add_img(input int s, input int nbeats);
        in_beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b.data = DW'($urandom);
            b.keep = WORDS'($urandom);
            b.last = (k == nbeats - 1);
            src_q[s].push_back(b);
        end
    endtask

    task automatic clear_logs();
        hdr_log.delete();
        gap_log.delete();
        out_cnt   = 0;
        req_cyc   = -1;
        out_cyc   = -1;
        seen_busy = 1'b0;
        idle_run  = 0;
    endtask

    // Runs in the middle of the cycle: checks outputs and advances the model
    // to what the DUT should do at the coming clock edge.
    task automatic monitor();
        logic [N_SRC-1:0] mask;
        logic [63:0]      obs;
        out_beat_t        e;
        cyc++;
        acc = '0;
        if (rst) begin
            mdl_busy   = 1'b0;
            mdl_grant  = 0;
            mdl_last   = N_SRC - 1;
            exp_q.delete();
            stall_prev = 1'b0;
            return;
        end
        chk("busy", 64'(busy), 64'(mdl_busy));
        mask = mdl_busy ? (N_SRC'(1) << mdl_grant) : '0;
        chk("ready_mask", 64'(s_ready & ~mask), 64'd0);
`ifdef AXIS_PIXELS_ARB_REG_OUT_EN
        if (mdl_busy) chk("ready_g", 64'(bit_at(s_ready, mdl_grant)), 64'(exp_q.size() < 2));
        chk("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
`else
        if (mdl_busy) chk("ready_g", 64'(bit_at(s_ready, mdl_grant)), 64'(m_ready));
        chk("m_valid", 64'(m_valid), 64'(mdl_busy && bit_at(s_valid, mdl_grant)));
`endif
        acc = s_valid & s_ready;
        if (mdl_busy && bit_at(acc, mdl_grant)) begin
            e.data  = src_q[mdl_grant][0].data;
            e.keep  = src_q[mdl_grant][0].keep;
            e.last  = src_q[mdl_grant][0].last;
            e.first = (mdl_idx == 0);
            e.src   = mdl_grant;
            exp_q.push_back(e);
            mdl_idx++;
        end
        obs = pack(m_last, m_first, int'(m_src), m_keep, m_data);
        if (stall_prev) chk("stall_hold", {m_valid, obs[62:0]}, {1'b1, stall_val[62:0]});
        if (req_cyc < 0 && |s_valid) req_cyc = cyc;
        if (out_cyc < 0 && m_valid) out_cyc = cyc;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("out_extra", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", obs, pack(e.last, e.first, e.src, e.keep, e.data));
            end
            out_cnt++;
            if (m_first) hdr_log.push_back(int'(m_src));
        end
        stall_prev = m_valid && !m_ready;
        stall_val  = obs;
        if (busy) begin
            if (seen_busy && idle_run > 0) gap_log.push_back(idle_run);
            seen_busy = 1'b1;
            idle_run  = 0;
        end else begin
            idle_run++;
        end
        if (!mdl_busy) begin
            if (|s_valid) begin
                mdl_grant = rr_pick(s_valid, mdl_last);
                mdl_last  = mdl_grant;
                mdl_busy  = 1'b1;
                mdl_idx   = 0;
            end
        end else if (bit_at(acc, mdl_grant) && src_q[mdl_grant][0].last) begin
            mdl_busy = 1'b0;
        end
    endtask

    // Just after the clock edge: retire accepted beats, present the next ones.
    task automatic drive();
        logic [N_SRC-1:0] nv;
        bit               hold;
        bit               pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        nv = s_valid;
        for (int i = 0; i < N_SRC; i++) begin
            if (rst) src_q[i].delete();
            else if (bit_at(acc, i)) void'(src_q[i].pop_front());
            hold = bit_at(s_valid, i) && !bit_at(acc, i) && (src_q[i].size() > 0);
            if (!hold) nv[i] = (src_q[i].size() > 0) && ($urandom_range(99) >= gap_pct);
            if (src_q[i].size() > 0) begin
                s_data[i] = src_q[i][0].data;
                s_keep[i] = src_q[i][0].keep;
                s_last[i] = src_q[i][0].last;
            end else begin
                s_data[i] = DW'($urandom);
                s_keep[i] = WORDS'($urandom);
                s_last[i] = 1'($urandom);
            end
        end
        s_valid = nv;
        case (rdy_mode)
            1:       m_ready = pat[rdy_cnt % 4];
            2:       m_ready = 1'($urandom);
            default: m_ready = 1'b1;
        endcase
        rdy_cnt++;
    endtask

    task automatic step();
        @(negedge aclk);
        monitor();
        @(posedge aclk);
        #1;
        drive();
    endtask

    task automatic chk_reset();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last",  64'(m_last),  64'd0);
        chk("rst_m_first", 64'(m_first), 64'd0);
        chk("rst_m_src",   64'(m_src),   64'd0);
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        chk_reset();
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input int max);
        int  k = 0;
        bit  done = 1'b0;
        while (k < max && !done) begin
            step();
            k++;
            done = (exp_q.size() == 0) && !mdl_busy;
            for (int i = 0; i < N_SRC; i++) if (src_q[i].size() != 0) done = 1'b0;
        end
        chk("drain", 64'(done), 64'd1);
    endtask

    initial begin
        int total;
        int k;

        // Single source, header + 3 pixels
        do_reset();
        clear_logs();
        rdy_mode = 0; gap_pct = 0;
        add_img(0, 4);
        run_until_idle(100);
        chk("s1_beats", 64'(out_cnt), 64'd4);
        chk("s1_order", 64'(enc_log()), 64'd1);
`ifdef AXIS_PIXELS_ARB_REG_OUT_EN
        chk("s1_latency", 64'(out_cyc - req_cyc), 64'd2);
`else
        chk("s1_latency", 64'(out_cyc - req_cyc), 64'd1);
`endif

        // Contention between src0 and src1
        do_reset();
        clear_logs();
        add_img(0, 2); add_img(0, 2);
        add_img(1, 2); add_img(1, 2);
        run_until_idle(200);
        chk("s2_order", 64'(enc_log()), 64'd1212);
        chk("s2_ngaps", 64'(gap_log.size()), 64'd3);
        foreach (gap_log[i]) chk("s2_gap", 64'(gap_log[i]), 64'd1);

        // Back-pressure on src1
        clear_logs();
        rdy_mode = 1; rdy_cnt = 0;
        add_img(1, 5);
        run_until_idle(200);
        chk("s3_beats", 64'(out_cnt), 64'd5);
        chk("s3_order", 64'(enc_log()), 64'd2);

        // Header-only image from src2
        clear_logs();
        rdy_mode = 0;
        add_img(2, 1);
        run_until_idle(100);
        chk("s4_beats", 64'(out_cnt), 64'd1);
        chk("s4_order", 64'(enc_log()), 64'd3);
        chk("s4_busy", 64'(busy), 64'd0);

        // Mid-image reset during src1 beat 2 of 5
        clear_logs();
        add_img(1, 5);
        k = 0;
        while (k < 50 && src_q[1].size() != 4) begin
            step();
            k++;
        end
        chk("s5_beat2", 64'(src_q[1].size()), 64'd4);
        rst = 1'b1;
        step();
        chk_reset();
        rst = 1'b0;
        clear_logs();
        add_img(1, 3);
        add_img(0, 2);
        run_until_idle(200);
        chk("s5_order", 64'(enc_log()), 64'd12);

        // Pointer wrap: src2 first, then src0 ahead of src1
        do_reset();
        clear_logs();
        add_img(2, 2);
        k = 0;
        while (k < 20 && !mdl_busy) begin
            step();
            k++;
        end
        add_img(0, 2);
        add_img(1, 2);
        run_until_idle(200);
        chk("s6_order", 64'(enc_log()), 64'd312);

        // Randomized traffic with gaps and random back-pressure
        clear_logs();
        rdy_mode = 2; gap_pct = 30;
        total = 0;
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 5; j++) begin
                int nb;
                nb = int'($urandom_range(6, 1));
                add_img(int'($urandom_range(N_SRC - 1)), nb);
                total += nb;
            end
            for (int j = 0; j < int'($urandom_range(20)); j++) step();
        end
        run_until_idle(5000);
        chk("rand_beats", 64'(out_cnt), 64'(total));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
